// File: rtl/mc_alu.sv
// -----------------------------------------------------------------------------
// mc_alu -- multi-cycle integer ALU with iterative multiply and divide.
//
// Base operations (add/sub/logic/compare/shift) complete in a single cycle:
// the accepting edge writes the result and enters DONE. Multiply and divide
// operations run one bit per cycle for WIDTH cycles in CALC; the last
// iteration also applies the sign correction and writes the result.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   operation request, sampled only while idle
//   a, b      in   WIDTH-bit operands, captured on an accepted start
//   alu_ctrl  in   5-bit operation select, captured on an accepted start
//   result    out  registered WIDTH-bit result
//   zero      out  registered flag, result == 0
//   overflow  out  registered flag, unsigned a < b (base ops only)
//   busy      out  high while an operation is in CALC or DONE
//   done      out  one-cycle pulse when result is valid
// -----------------------------------------------------------------------------
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    // Operation encodings
    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLT    = 5'b00101;
    localparam logic [4:0] OP_SLTU   = 5'b00110;
    localparam logic [4:0] OP_SLL    = 5'b00111;
    localparam logic [4:0] OP_SRL    = 5'b01000;
    localparam logic [4:0] OP_SRA    = 5'b01001;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    // Iteration counter runs 0 .. WIDTH-1
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONES_W = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return (~x) + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return (~x) + ONE_2W;
    endfunction

    // Single-cycle operations; unknown encodings yield zero.
    function automatic logic [WIDTH-1:0] base_op(input logic [4:0]       op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] r;
        sh = y[SHW-1:0];
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = $unsigned($signed(x) >>> sh);
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [4:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier / dividend -> quotient
    logic             qneg_q, qneg_d;   // negate product or quotient at the end
    logic             rneg_q, rneg_d;   // negate remainder at the end
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Combinational helpers
    logic             is_mop_s;
    logic             a_sgn_s, b_sgn_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH-1:0] base_res_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_fits_s;
    logic [WIDTH-1:0] div_diff_s;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0] quot_s, rem_s;
    logic [WIDTH-1:0] m_res_s;

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Decode the incoming request: M-op class and operand signedness.
    always_comb begin
        is_mop_s = (alu_ctrl[4:3] == 2'b10);
        case (alu_ctrl)
            OP_MULH, OP_DIV, OP_REM: begin
                a_sgn_s = a[WIDTH-1];
                b_sgn_s = b[WIDTH-1];
            end
            OP_MULHSU: begin
                a_sgn_s = a[WIDTH-1];
                b_sgn_s = 1'b0;
            end
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
            end
        endcase
        if (a_sgn_s) begin
            a_mag_s = neg_w(a);
        end else begin
            a_mag_s = a;
        end
        if (b_sgn_s) begin
            b_mag_s = neg_w(b);
        end else begin
            b_mag_s = b;
        end
        base_res_s = base_op(alu_ctrl, a, b);
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        // Multiply: conditionally add multiplicand into the high half, then
        // shift the whole {hi, lo} pair right by one.
        if (lo_q[0]) begin
            mul_sum_s = {1'b0, hi_q} + {1'b0, opnd_q};
        end else begin
            mul_sum_s = {1'b0, hi_q};
        end
        // Divide: shift the next dividend bit into the partial remainder and
        // subtract the divisor if it fits. The true difference is below the
        // divisor, so the low WIDTH bits of the subtraction are exact.
        div_shift_s = {hi_q, lo_q[WIDTH-1]};
        div_fits_s  = (div_shift_s >= {1'b0, opnd_q});
        div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_q;
        if (op_q[2]) begin
            if (div_fits_s) begin
                step_hi_s = div_diff_s;
                step_lo_s = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
        end
    end

    // Final-cycle sign correction, special cases and result selection.
    always_comb begin
        prod_s = {step_hi_s, step_lo_s};
        if (qneg_q) begin
            prod_fix_s = neg_2w(prod_s);
            quot_s     = neg_w(step_lo_s);
        end else begin
            prod_fix_s = prod_s;
            quot_s     = step_lo_s;
        end
        if (rneg_q) begin
            rem_s = neg_w(step_hi_s);
        end else begin
            rem_s = step_hi_s;
        end
        // Most-negative / -1 falls out naturally: magnitude quotient equals
        // the most-negative pattern with no sign flip, remainder is zero.
        case (op_q)
            OP_MUL:                         m_res_s = prod_fix_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   m_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: begin
                if (b_q == {WIDTH{1'b0}}) begin
                    m_res_s = ONES_W;
                end else begin
                    m_res_s = quot_s;
                end
            end
            OP_REM, OP_REMU: begin
                if (b_q == {WIDTH{1'b0}}) begin
                    m_res_s = a_q;
                end else begin
                    m_res_s = rem_s;
                end
            end
            default: m_res_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM next-state logic.
    always_comb begin
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mop_s) begin
                        state_d = S_CALC;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so busy/done come from flops.
    always_comb begin
        case (state_d)
            S_CALC: begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath next-state: capture on accept, iterate in CALC, write results.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    op_d  = alu_ctrl;
                    cnt_d = {CW{1'b0}};
                    if (is_mop_s) begin
                        qneg_d = a_sgn_s ^ b_sgn_s;
                        rneg_d = a_sgn_s;
                        hi_d   = {WIDTH{1'b0}};
                        if (alu_ctrl[2]) begin
                            opnd_d = b_mag_s;
                            lo_d   = a_mag_s;
                        end else begin
                            opnd_d = a_mag_s;
                            lo_d   = b_mag_s;
                        end
                    end else begin
                        result_d = base_res_s;
                        zero_d   = (base_res_s == {WIDTH{1'b0}});
                        ovf_d    = (a < b);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_CALC: begin
                hi_d  = step_hi_s;
                lo_d  = step_lo_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    result_d = m_res_s;
                    zero_d   = (m_res_s == {WIDTH{1'b0}});
                    ovf_d    = 1'b0;
                end else begin
                    result_d = result_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // All state registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            op_q     <= 5'b00000;
            cnt_q    <= {CW{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// -----------------------------------------------------------------------------
// tb_mc_alu -- directed, table-driven bench for mc_alu (WIDTH = 32).
// Latency is counted in rising edges starting with the accepting edge:
// base ops finish at 1, multiply/divide at WIDTH+1 = 33.
// -----------------------------------------------------------------------------
module tb_mc_alu;

    localparam int W = 32;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLT    = 5'b00101;
    localparam logic [4:0] OP_SLTU   = 5'b00110;
    localparam logic [4:0] OP_SLL    = 5'b00111;
    localparam logic [4:0] OP_SRL    = 5'b01000;
    localparam logic [4:0] OP_SRA    = 5'b01001;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = 32'h0;
    logic [W-1:0] b = 32'h0;
    logic [4:0]   alu_ctrl = 5'b00000;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .alu_ctrl (alu_ctrl),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          lat;
        int          inj;   // cycle at which to pulse a stray start (0 = none)
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] av,
                                input logic [31:0] bv, input logic [31:0] res,
                                input logic ovf, input int lat, input int inj);
        vec_t v;
        v.op = op; v.a = av; v.b = bv; v.res = res;
        v.ovf = ovf; v.lat = lat; v.inj = inj;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE and wait (bounded) for done.
    task automatic run_op(input logic [4:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int inj,
                          output int lat, output int busy_gap);
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        alu_ctrl = op; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_gap = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_gap++;
            if (lat == inj) begin
                start = 1'b1; alu_ctrl = OP_ADD; a = 32'h1; b = 32'h1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin : main
        int lat;
        int gap;
        bit seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'h0, zero}, 32'h1);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table: op, a, b, expected result, expected overflow, latency, inject
        vecs.push_back(mk(OP_ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 0));
        vecs.push_back(mk(OP_SUB,    32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1, 0));
        vecs.push_back(mk(OP_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1, 0));
        vecs.push_back(mk(OP_OR,     32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1, 0));
        vecs.push_back(mk(OP_XOR,    32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b1, 1, 0));
        vecs.push_back(mk(OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 0));
        vecs.push_back(mk(OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 0));
        vecs.push_back(mk(OP_SLT,    32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(OP_SLTU,   32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1, 0));
        vecs.push_back(mk(OP_SLL,    32'h00000001, 32'h0000003F, 32'h80000000, 1'b1, 1, 0));
        vecs.push_back(mk(OP_SRL,    32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1, 0));
        vecs.push_back(mk(OP_SRA,    32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1, 0));
        vecs.push_back(mk(OP_SRA,    32'h40000000, 32'h00000021, 32'h20000000, 1'b0, 1, 0));
        vecs.push_back(mk(5'b01010,  32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1, 0));
        vecs.push_back(mk(5'b11000,  32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33, 0));
        vecs.push_back(mk(OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 33, 0));
        vecs.push_back(mk(OP_MULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 33, 0));
        vecs.push_back(mk(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, 0));
        vecs.push_back(mk(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, 0));
        vecs.push_back(mk(OP_MULHSU, 32'h00000002, 32'h80000000, 32'h00000001, 1'b0, 33, 0));
        vecs.push_back(mk(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 0));
        vecs.push_back(mk(OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 33, 0));
        vecs.push_back(mk(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 33, 0));
        vecs.push_back(mk(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 33, 0));
        vecs.push_back(mk(OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33, 0));
        vecs.push_back(mk(OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 0));
        vecs.push_back(mk(OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 33, 0));
        vecs.push_back(mk(OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 33, 0));
        vecs.push_back(mk(OP_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33, 0));
        vecs.push_back(mk(OP_REM,    32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 33, 0));
        vecs.push_back(mk(OP_DIV,    32'h80000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33, 0));
        vecs.push_back(mk(OP_REMU,   32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 33, 0));
        vecs.push_back(mk(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33, 5));
        vecs.push_back(mk(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, 0));

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inj, lat, gap);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_zero", i), {31'h0, zero}, {31'h0, (vecs[i].res == 32'h0)});
            check($sformatf("v%0d_ovf", i), {31'h0, overflow}, {31'h0, vecs[i].ovf});
            if (vecs[i].lat > 1) begin
                check($sformatf("v%0d_busy_gap", i), gap, 0);
            end
        end

        // Back-to-back: start held through the DONE cycle is ignored there
        run_op(OP_ADD, 32'd10, 32'd20, 0, lat, gap);
        check("b2b_first_result", result, 32'd30);
        alu_ctrl = OP_SUB; a = 32'h1; b = 32'h2; start = 1'b1;
        @(posedge clk); #1;
        check("b2b_ignored_busy", {31'h0, busy}, 32'h0);
        check("b2b_ignored_done", {31'h0, done}, 32'h0);
        check("b2b_result_held", result, 32'd30);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_second_done", {31'h0, done}, 32'h1);
        check("b2b_second_result", result, 32'hFFFFFFFF);
        check("b2b_second_ovf", {31'h0, overflow}, 32'h1);

        // Reset asserted during cycle 10 of a DIVU
        @(posedge clk); #1;
        alu_ctrl = OP_DIVU; a = 32'h00000064; b = 32'h00000007; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("midcalc_busy", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("arst_result", result, 32'h0);
        check("arst_zero", {31'h0, zero}, 32'h1);
        check("arst_ovf", {31'h0, overflow}, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("arst_no_done", {31'h0, seen}, 32'h0);
        run_op(OP_ADD, 32'd2, 32'd3, 0, lat, gap);
        check("post_rst_lat", lat, 1);
        check("post_rst_result", result, 32'd5);
        check("post_rst_zero", {31'h0, zero}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
